// File: rtl/instr_mem_loader_if.sv
// Stream input and byte-write memory port of the instruction memory loader.
// The loader takes the slave side; the word source / memory side takes master.
interface instr_mem_loader_if #(
    parameter int bus_length = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_word;
    logic                  mem_we;
    logic [bus_length-1:0] mem_waddr;
    logic [7:0]            mem_wdata;

    modport slave (
        input  in_valid, in_word,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );

    modport master (
        output in_valid, in_word,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time loader: splits 32-bit instruction words into 4 MSB-first byte writes
// and holds the core in reset while a load is running.
module instr_mem_loader #(
    parameter int bus_length   = 64,
    parameter int MEM_BYTES    = 256,
    parameter int WORD_COUNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [bus_length-1:0]   base_addr,
    input  logic [WORD_COUNT_W-1:0] num_words,
    instr_mem_loader_if.slave       bus,
    output logic                    busy,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    err
);
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    // Highest byte address at which a whole word still fits.
    localparam logic [bus_length-1:0] LAST_WORD_ADDR = bus_length'(MEM_BYTES - 4);

    state_t                  state, state_nxt;
    logic [bus_length-1:0]   ptr;
    logic [WORD_COUNT_W-1:0] left;
    logic [31:0]             word_sr;
    logic [1:0]              byte_idx;
    logic                    err_q;
    logic                    overflow;
    logic                    handshake;

    assign overflow  = (ptr > LAST_WORD_ADDR);
    assign handshake = (state == ACCEPT) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        busy          = (state != IDLE);
        cpu_hold      = (state != IDLE);
        done          = 1'b0;
        err           = err_q;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_words == '0) ? DONE : ACCEPT;
            end
            ACCEPT: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = overflow ? DONE : WRITE;
            end
            WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = ptr;
                bus.mem_wdata = word_sr[31:24];
                if (byte_idx == 2'd3)
                    state_nxt = (left == WORD_COUNT_W'(1)) ? DONE : ACCEPT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: the word is shifted left so the byte being written is always [31:24].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            left     <= '0;
            word_sr  <= '0;
            byte_idx <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr   <= base_addr;
                        left  <= num_words;
                        err_q <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (handshake) begin
                        if (overflow) begin
                            err_q <= 1'b1;
                        end else begin
                            word_sr  <= bus.in_word;
                            byte_idx <= 2'd0;
                        end
                    end
                end
                WRITE: begin
                    ptr      <= ptr + 1'b1;
                    word_sr  <= {word_sr[23:0], 8'h00};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) left <= left - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of load vectors plus hand-written
// sequences for start-while-busy and reset in the middle of a word.
module tb_instr_mem_loader;
    localparam int BL = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [BL-1:0] base_addr;
    logic [7:0]    num_words;
    logic          busy, cpu_hold, done, err;

    always #5 clk = ~clk;

    instr_mem_loader_if #(.bus_length(BL)) ifc();

    instr_mem_loader #(.bus_length(BL), .MEM_BYTES(256), .WORD_COUNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .bus       (ifc),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    // Byte-wide instruction memory and event counters.
    bit [7:0] mem [256];
    int wr_cnt, rdy_cnt, done_cnt, oob_cnt;

    always @(posedge clk) begin
        if (ifc.mem_we) begin
            if (ifc.mem_waddr < 256) mem[ifc.mem_waddr[7:0]] <= ifc.mem_wdata;
            else                     oob_cnt <= oob_cnt + 1;
            wr_cnt <= wr_cnt + 1;
        end
        if (ifc.in_ready) rdy_cnt  <= rdy_cnt + 1;
        if (done)         done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [63:0] base;
        logic [7:0]  n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          stall;
        int          exp_wr;
        logic        exp_err;
        int          exp_rdy;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic apply(input vec_t v, input string tag);
        int wr0, rd0, dn0, lat, t, mid, a;
        logic saw;
        logic [31:0] w;
        logic [7:0] eb;
        wr0 = wr_cnt; rd0 = rdy_cnt; dn0 = done_cnt;
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        start = 1'b1; base_addr = v.base; num_words = v.n;
        @(negedge clk);
        start = 1'b0; base_addr = '1; num_words = 8'hFF;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_hold_rise"}, cpu_hold, 1);
        saw = 1'b0; lat = 0;
        if (v.n == 0) begin
            lat = 1;
            while (!done && lat < 30) begin @(negedge clk); lat++; end
            saw = done;
        end
        for (int i = 0; i < int'(v.n) && !saw; i++) begin
            w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : v.w2;
            if (v.stall > 0) begin
                ifc.in_valid = 1'b0;
                repeat (v.stall / 2) @(negedge clk);
                mid = wr_cnt;
                repeat (v.stall - v.stall / 2) @(negedge clk);
                check({tag, "_stall_no_we"}, wr_cnt, mid);
            end
            ifc.in_word = w; ifc.in_valid = 1'b1;
            t = 0;
            while (!ifc.in_ready && !done && t < 50) begin @(negedge clk); t++; end
            if (done) begin saw = 1'b1; break; end
            if (t >= 50) begin check({tag, "_accept_timeout"}, t, 0); break; end
            @(posedge clk);
            @(negedge clk);
            if (i == int'(v.n) - 1) begin
                lat = 1;
                while (!done && lat < 30) begin @(negedge clk); lat++; end
                saw = done;
            end
        end
        ifc.in_valid = 1'b0;
        check({tag, "_done_seen"}, saw, 1);
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_err"}, err, v.exp_err);
        @(negedge clk);
        check({tag, "_done_pulse_1cyc"}, done, 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_hold_fall"}, cpu_hold, 0);
        check({tag, "_err_hold"}, err, v.exp_err);
        check({tag, "_writes"}, wr_cnt - wr0, v.exp_wr);
        check({tag, "_done_count"}, done_cnt - dn0, 1);
        if (v.exp_rdy >= 0) check({tag, "_ready_cycles"}, rdy_cnt - rd0, v.exp_rdy);
        for (int j = 0; j < v.exp_wr; j++) begin
            w  = (j / 4 == 0) ? v.w0 : (j / 4 == 1) ? v.w1 : v.w2;
            eb = w[31 - 8 * (j % 4) -: 8];
            a  = int'(v.base) + j;
            check({tag, "_mem_byte"}, mem[a[7:0]], eb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, dn0, t;
        vec_t rv;
        vecs[0] = '{base:64'd0,   n:8'd1, w0:32'h001101B3, w1:32'h0,        w2:32'h0,
                    stall:0,  exp_wr:4,  exp_err:1'b0, exp_rdy:1,  exp_lat:5};
        vecs[1] = '{base:64'd4,   n:8'd3, w0:32'h11223344, w1:32'h55667788, w2:32'h99AABBCC,
                    stall:0,  exp_wr:12, exp_err:1'b0, exp_rdy:3,  exp_lat:5};
        vecs[2] = '{base:64'd32,  n:8'd2, w0:32'hDEADBEEF, w1:32'h0BADF00D, w2:32'h0,
                    stall:10, exp_wr:8,  exp_err:1'b0, exp_rdy:-1, exp_lat:5};
        vecs[3] = '{base:64'd252, n:8'd2, w0:32'hCAFEBABE, w1:32'h12345678, w2:32'h0,
                    stall:0,  exp_wr:4,  exp_err:1'b1, exp_rdy:2,  exp_lat:1};
        vecs[4] = '{base:64'd100, n:8'd0, w0:32'h0,        w1:32'h0,        w2:32'h0,
                    stall:0,  exp_wr:0,  exp_err:1'b0, exp_rdy:0,  exp_lat:1};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        ifc.in_valid = 1'b0; ifc.in_word = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", ifc.in_ready, 0);
        check("rst_we", ifc.mem_we, 0);
        check("rst_waddr", ifc.mem_waddr, 0);
        check("rst_wdata", ifc.mem_wdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 5; k++) apply(vecs[k], $sformatf("vec%0d", k));

        check("add_x3_b0", mem[0], 8'h00);
        check("add_x3_b1", mem[1], 8'h11);
        check("add_x3_b2", mem[2], 8'h01);
        check("add_x3_b3", mem[3], 8'hB3);
        check("three_w_last", mem[15], 8'hCC);
        check("top_word_252", mem[252], 8'hCA);
        check("top_word_255", mem[255], 8'hBE);
        check("no_oob_write", oob_cnt, 0);

        // A second start while the loader is busy must not relatch base/count.
        wr0 = wr_cnt; dn0 = done_cnt;
        @(negedge clk);
        start = 1'b1; base_addr = 64'd40; num_words = 8'd1;
        @(negedge clk);
        base_addr = 64'd200; num_words = 8'd5;
        @(negedge clk);
        start = 1'b0;
        ifc.in_word = 32'h5A5AA5A5; ifc.in_valid = 1'b1;
        t = 0;
        while (!ifc.in_ready && t < 50) begin @(negedge clk); t++; end
        check("busy_start_accept", ifc.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        t = 0;
        while (!done && t < 30) begin @(negedge clk); t++; end
        check("busy_start_done", done, 1);
        @(negedge clk);
        check("busy_start_idle", busy, 0);
        check("busy_start_writes", wr_cnt - wr0, 4);
        check("busy_start_dones", done_cnt - dn0, 1);
        check("busy_start_m40", mem[40], 8'h5A);
        check("busy_start_m43", mem[43], 8'hA5);
        check("busy_start_m200", mem[200], 8'h00);

        // Reset while the second byte of a word is on the bus.
        @(negedge clk);
        start = 1'b1; base_addr = 64'd64; num_words = 8'd1;
        @(negedge clk);
        start = 1'b0;
        ifc.in_word = 32'hA1B2C3D4; ifc.in_valid = 1'b1;
        t = 0;
        while (!ifc.in_ready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("mid_we_before", ifc.mem_we, 1);
        check("mid_addr_before", ifc.mem_waddr, 64'd65);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", ifc.mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_ready", ifc.in_ready, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", busy, 0);
        check("mid_partial_b0", mem[64], 8'hA1);
        check("mid_partial_b1", mem[65], 8'h00);
        rv = '{base:64'd64, n:8'd1, w0:32'h0F1E2D3C, w1:32'h0, w2:32'h0,
               stall:0, exp_wr:4, exp_err:1'b0, exp_rdy:1, exp_lat:5};
        apply(rv, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
